// File: rtl/step_dir_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : step_dir_decoder
//  Description : Receive-side STEP/DIR decoder. Synchronizes and deglitches
//                the STEP and DIR lines, counts accepted STEP rising edges
//                into a signed position, and reports per-move step count,
//                step period and moving/idle status.
//  Ports       : i_clk_100k     - 100 kHz system clock
//                i_rst          - asynchronous active-high reset
//                i_step, i_dir  - asynchronous STEP / DIR lines
//                i_zero         - one-cycle strobe, clears position/count/err
//                o_position     - signed position (wraps)
//                o_step_count   - steps in current/last move (saturates)
//                o_period       - cycles between last two edges (saturates)
//                o_period_valid - o_period measured within current move
//                o_step_tick    - one-cycle pulse per accepted edge
//                o_moving       - move in progress
//                o_ready        - priming complete
//                o_dir_err      - sticky: DIR changed while STEP high
//  Revision    : 1.0 - initial release
// ============================================================================
module step_dir_decoder #(
  parameter int          FILTER_CYCLES = 4,
  parameter logic [15:0] IDLE_TIMEOUT  = 16'd1000,
  parameter int          POS_WIDTH     = 24
) (
  input  logic                 i_clk_100k,
  input  logic                 i_rst,
  input  logic                 i_step,
  input  logic                 i_dir,
  input  logic                 i_zero,
  output logic [POS_WIDTH-1:0] o_position,
  output logic [POS_WIDTH-1:0] o_step_count,
  output logic [15:0]          o_period,
  output logic                 o_period_valid,
  output logic                 o_step_tick,
  output logic                 o_moving,
  output logic                 o_ready,
  output logic                 o_dir_err
);

  typedef enum logic [1:0] {
    S_PRIME  = 2'd0,
    S_IDLE   = 2'd1,
    S_MOVING = 2'd2
  } state_t;

  localparam logic [7:0]           c_filt_last = 8'(FILTER_CYCLES - 1);
  localparam logic [15:0]          c_idle_last = IDLE_TIMEOUT - 16'd1;
  localparam logic [POS_WIDTH-1:0] c_one       = {{(POS_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [POS_WIDTH-1:0] c_ones      = {POS_WIDTH{1'b1}};

  state_t               r_state;
  logic [1:0]           r_prime_cnt;
  logic                 r_step_s1, r_step_s2, r_dir_s1, r_dir_s2;
  logic                 r_step_f, r_dir_f;
  logic [7:0]           r_step_cnt, r_dir_cnt;
  logic [POS_WIDTH-1:0] r_position, r_step_count;
  logic [15:0]          r_period, r_timer, r_idle;
  logic                 r_period_valid, r_tick, r_moving, r_ready, r_dir_err;

  logic w_prime_done;
  logic w_step_upd, w_dir_upd, w_rise, w_dir_toggle;

  assign w_prime_done = (r_state == S_PRIME) && (r_prime_cnt == 2'd2);

  // A filter flips on the cycle its counter would reach FILTER_CYCLES.
  assign w_step_upd   = (r_step_s2 != r_step_f) && (r_step_cnt == c_filt_last);
  assign w_dir_upd    = (r_dir_s2 != r_dir_f) && (r_dir_cnt == c_filt_last);
  assign w_rise       = (r_state != S_PRIME) && w_step_upd && r_step_s2;
  assign w_dir_toggle = (r_state != S_PRIME) && w_dir_upd;

  // Two-flop synchronizers
  always_ff @(posedge i_clk_100k or posedge i_rst) begin
    if (i_rst) begin
      r_step_s1 <= 1'b0;
      r_step_s2 <= 1'b0;
      r_dir_s1  <= 1'b0;
      r_dir_s2  <= 1'b0;
    end else begin
      r_step_s1 <= i_step;
      r_step_s2 <= r_step_s1;
      r_dir_s1  <= i_dir;
      r_dir_s2  <= r_dir_s1;
    end
  end

  // Deglitch filters. While priming they are held, then loaded directly so a
  // line already high at reset release is not mistaken for an edge.
  always_ff @(posedge i_clk_100k or posedge i_rst) begin
    if (i_rst) begin
      r_step_f   <= 1'b0;
      r_dir_f    <= 1'b0;
      r_step_cnt <= 8'd0;
      r_dir_cnt  <= 8'd0;
    end else if (r_state == S_PRIME) begin
      r_step_cnt <= 8'd0;
      r_dir_cnt  <= 8'd0;
      if (w_prime_done) begin
        r_step_f <= r_step_s2;
        r_dir_f  <= r_dir_s2;
      end
    end else begin
      if (r_step_s2 == r_step_f) begin
        r_step_cnt <= 8'd0;
      end else if (w_step_upd) begin
        r_step_f   <= r_step_s2;
        r_step_cnt <= 8'd0;
      end else begin
        r_step_cnt <= r_step_cnt + 8'd1;
      end

      if (r_dir_s2 == r_dir_f) begin
        r_dir_cnt <= 8'd0;
      end else if (w_dir_upd) begin
        r_dir_f   <= r_dir_s2;
        r_dir_cnt <= 8'd0;
      end else begin
        r_dir_cnt <= r_dir_cnt + 8'd1;
      end
    end
  end

  // Control FSM with counters and registered outputs
  always_ff @(posedge i_clk_100k or posedge i_rst) begin
    if (i_rst) begin
      r_state        <= S_PRIME;
      r_prime_cnt    <= 2'd0;
      r_position     <= '0;
      r_step_count   <= '0;
      r_period       <= 16'd0;
      r_timer        <= 16'd0;
      r_idle         <= 16'd0;
      r_period_valid <= 1'b0;
      r_tick         <= 1'b0;
      r_moving       <= 1'b0;
      r_ready        <= 1'b0;
      r_dir_err      <= 1'b0;
    end else begin
      r_tick <= w_rise;

      case (r_state)
        S_PRIME: begin
          if (w_prime_done) begin
            r_ready <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            r_prime_cnt <= r_prime_cnt + 2'd1;
          end
        end

        S_IDLE: begin
          if (w_rise) begin
            r_step_count   <= c_one;
            r_period_valid <= 1'b0;
            r_timer        <= 16'd1;
            r_idle         <= 16'd0;
            r_moving       <= 1'b1;
            r_state        <= S_MOVING;
          end
        end

        S_MOVING: begin
          if (w_rise) begin
            r_period       <= r_timer;
            r_period_valid <= 1'b1;
            r_timer        <= 16'd1;
            r_idle         <= 16'd0;
            if (r_step_count != c_ones) begin
              r_step_count <= r_step_count + c_one;
            end
          end else begin
            if (r_timer != 16'hFFFF) begin
              r_timer <= r_timer + 16'd1;
            end
            // Leave on the cycle the idle count reaches IDLE_TIMEOUT.
            if (r_idle == c_idle_last) begin
              r_moving <= 1'b0;
              r_state  <= S_IDLE;
            end
            r_idle <= r_idle + 16'd1;
          end
        end

        default: r_state <= S_PRIME;
      endcase

      // DIR sampled before the edge cycle sets the count direction.
      if (w_rise) begin
        r_position <= r_dir_f ? (r_position + c_one) : (r_position - c_one);
      end

      if (w_dir_toggle && r_step_f) begin
        r_dir_err <= 1'b1;
      end

      // Zero strobe overrides any same-cycle edge or error set.
      if (i_zero) begin
        r_position   <= '0;
        r_step_count <= '0;
        r_dir_err    <= 1'b0;
      end
    end
  end

  assign o_position     = r_position;
  assign o_step_count   = r_step_count;
  assign o_period       = r_period;
  assign o_period_valid = r_period_valid;
  assign o_step_tick    = r_tick;
  assign o_moving       = r_moving;
  assign o_ready        = r_ready;
  assign o_dir_err      = r_dir_err;

endmodule
`default_nettype wire

// File: tb/tb_step_dir_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_step_dir_decoder
//  Description : Directed self-checking bench for step_dir_decoder
//                (FILTER_CYCLES=4, IDLE_TIMEOUT=200, POS_WIDTH=24).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_step_dir_decoder;

  localparam int c_timeout = 200;

  logic        clk = 1'b0;
  logic        rst, step, dir, zero;
  logic [23:0] position, step_count;
  logic [15:0] period;
  logic        period_valid, step_tick, moving, ready, dir_err;

  int n_cmp = 0;
  int n_err = 0;
  int cycle = 0;
  int ticks = 0;
  int last_tick = 0;
  int c0;
  int t0;

  step_dir_decoder #(
    .FILTER_CYCLES(4),
    .IDLE_TIMEOUT (16'd200),
    .POS_WIDTH    (24)
  ) dut (
    .i_clk_100k    (clk),
    .i_rst         (rst),
    .i_step        (step),
    .i_dir         (dir),
    .i_zero        (zero),
    .o_position    (position),
    .o_step_count  (step_count),
    .o_period      (period),
    .o_period_valid(period_valid),
    .o_step_tick   (step_tick),
    .o_moving      (moving),
    .o_ready       (ready),
    .o_dir_err     (dir_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; sample 1 time unit after the edge.
  task automatic step_clk();
    @(posedge clk);
    #1;
    cycle++;
    if (step_tick) begin
      ticks++;
      last_tick = cycle;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step_clk();
  endtask

  task automatic pulse(input int hi, input int lo);
    step = 1'b1;
    run(hi);
    step = 1'b0;
    run(lo);
  endtask

  initial begin
    rst = 1'b1; step = 1'b1; dir = 1'b1; zero = 1'b0;
    run(3);
    check("reset_position", position, 0);
    check("reset_ready", ready, 0);
    check("reset_moving", moving, 0);

    // Prime with STEP held high: ready at the 3rd cycle, no tick.
    rst = 1'b0;
    ticks = 0;
    step_clk();
    check("prime_ready_c1", ready, 0);
    step_clk();
    check("prime_ready_c2", ready, 0);
    step_clk();
    check("prime_ready_c3", ready, 1);
    run(10);
    step = 1'b0;
    run(12);
    check("prime_no_tick", ticks, 0);
    check("prime_position", position, 0);

    // Forward move of 10 pulses, 50-cycle period.
    for (int p = 0; p < 10; p++) pulse(20, 30);
    check("fwd_ticks", ticks, 10);
    check("fwd_position", position, 24'd10);
    check("fwd_count", step_count, 24'd10);
    check("fwd_period", period, 16'd50);
    check("fwd_valid", period_valid, 1);
    check("fwd_moving", moving, 1);
    t0 = 0;
    while (moving && t0 < 3 * c_timeout) begin
      step_clk();
      t0++;
    end
    check("fwd_idle_delay", cycle - last_tick, c_timeout);

    // Glitch rejection and filter latency.
    ticks = 0;
    pulse(3, 20);
    check("glitch_no_tick", ticks, 0);
    step = 1'b1;
    c0 = cycle;
    run(5);
    step = 1'b0;
    run(30);
    check("latency_ticks", ticks, 1);
    check("latency_cycles", last_tick - c0, 6);
    check("new_move_count", step_count, 24'd1);
    check("new_move_valid", period_valid, 0);
    check("latency_position", position, 24'd11);
    run(c_timeout + 10);
    check("glitch_idle", moving, 0);

    // Reverse from zero, wraps below zero.
    zero = 1'b1;
    step_clk();
    zero = 1'b0;
    check("zero_position", position, 0);
    check("zero_count", step_count, 0);
    dir = 1'b0;
    run(10);
    pulse(20, 30);
    check("rev1_position", position, 24'hFFFFFF);
    check("rev1_count", step_count, 24'd1);
    check("rev1_valid", period_valid, 0);
    pulse(20, 30);
    check("rev2_position", position, 24'hFFFFFE);
    check("rev2_count", step_count, 24'd2);
    check("rev2_valid", period_valid, 1);
    check("rev2_period", period, 16'd50);

    // i_zero on the same cycle as an accepted edge.
    step = 1'b1;
    run(5);
    zero = 1'b1;
    step_clk();
    zero = 1'b0;
    check("coll_tick", step_tick, 1);
    check("coll_position", position, 0);
    check("coll_count", step_count, 0);
    check("coll_period", period, 16'd50);
    check("coll_moving", moving, 1);
    run(14);
    step = 1'b0;
    run(30);

    // DIR change while STEP filtered high.
    check("err_initial", dir_err, 0);
    step = 1'b1;
    run(10);
    dir = 1'b1;
    run(10);
    check("err_set", dir_err, 1);
    step = 1'b0;
    run(10);
    check("err_sticky", dir_err, 1);
    zero = 1'b1;
    step_clk();
    zero = 1'b0;
    check("err_cleared", dir_err, 0);
    run(10);

    // Reset in the middle of a move.
    for (int p = 0; p < 5; p++) pulse(20, 30);
    check("mid_position", position, 24'd5);
    check("mid_moving", moving, 1);
    rst = 1'b1;
    #1;
    check("async_position", position, 0);
    check("async_count", step_count, 0);
    check("async_moving", moving, 0);
    check("async_ready", ready, 0);
    check("async_period", period, 0);
    #3;
    rst = 1'b0;
    step_clk();
    check("reprime_c1", ready, 0);
    step_clk();
    check("reprime_c2", ready, 0);
    step_clk();
    check("reprime_c3", ready, 1);
    run(5);
    for (int p = 0; p < 3; p++) pulse(20, 30);
    check("after_rst_position", position, 24'd3);
    check("after_rst_count", step_count, 24'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
